// File: rtl/flag_unit.sv
// flag_unit -- two-stage condition-flag pipeline.
//
// Evaluates an ALU result into the architectural N/Z/C/V flag register.
// Stage 1 registers per-lane zero bits, the mode-selected sign bit and
// the side inputs. Stage 2 reduces the lane bits into Z and writes the
// flag register.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   valid_i       result_i and side inputs are valid this cycle
//   result_i      ALU result (REGISTER_LENGTH bits)
//   carry_i       ALU carry out
//   overflow_i    ALU signed overflow
//   set_flags_i   result updates the flag register
//   word_mode_i   evaluate only the low WORD_LENGTH bits
//   flush_i       kill all in-flight results
//   lane_zero_o   registered per-lane all-zero bits (LANES bits)
//   negative_o, zero_o, carry_o, overflow_o   flag register
//   flags_valid_o one-cycle pulse after a flag-register write
//
// Handshake: valid_i is a plain qualifier with no ready. Every cycle
// with valid_i=1 and flush_i=0 is accepted; there is no back-pressure.
module flag_unit #(
   parameter int REGISTER_LENGTH = 64,
   parameter int LANE_WIDTH      = 16,
   parameter int WORD_LENGTH     = 32,
   localparam int LANES          = REGISTER_LENGTH / LANE_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic [REGISTER_LENGTH-1:0] result_i,
   input  logic             carry_i,
   input  logic             overflow_i,
   input  logic             set_flags_i,
   input  logic             word_mode_i,
   input  logic             flush_i,
   output logic [LANES-1:0] lane_zero_o,
   output logic             negative_o,
   output logic             zero_o,
   output logic             carry_o,
   output logic             overflow_o,
   output logic             flags_valid_o
);

   localparam int WORD_LANES = WORD_LENGTH / LANE_WIDTH;

   // Per-lane zero detect: each lane is an independent LANE_WIDTH-bit NOR,
   // so the longest OR chain is one lane wide.
   logic [LANES-1:0] lane_zero_d;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign lane_zero_d[k] = ~|result_i[k*LANE_WIDTH +: LANE_WIDTH];
   end

   // Stage-1 state
   logic s1_valid;
   logic s1_sign;
   logic s1_carry;
   logic s1_overflow;
   logic s1_set_flags;
   logic s1_word_mode;

   // Stage-2 state: s2_valid/s2_set_flags describe the result that was
   // just presented to the flag register.
   logic s2_valid;
   logic s2_set_flags;

   logic accept;
   assign accept = valid_i & ~flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid     <= 1'b0;
         lane_zero_o  <= '0;
         s1_sign      <= 1'b0;
         s1_carry     <= 1'b0;
         s1_overflow  <= 1'b0;
         s1_set_flags <= 1'b0;
         s1_word_mode <= 1'b0;
      end else begin
         s1_valid <= accept;
         // lane_zero_o and the side registers only move on an accepted
         // input; idle and flushed cycles leave them as they were.
         if (accept) begin
            lane_zero_o  <= lane_zero_d;
            s1_sign      <= word_mode_i ? result_i[WORD_LENGTH-1]
                                        : result_i[REGISTER_LENGTH-1];
            s1_carry     <= carry_i;
            s1_overflow  <= overflow_i;
            s1_set_flags <= set_flags_i;
            s1_word_mode <= word_mode_i;
         end
      end
   end

   // Stage-2 reduction of the registered lane bits.
   logic z_reduced;
   always_comb begin
      z_reduced = &lane_zero_o;
      if (s1_word_mode) z_reduced = &lane_zero_o[WORD_LANES-1:0];
   end

   // A flush on the edge where a stage-1 result would retire kills it.
   logic write_en;
   assign write_en = s1_valid & s1_set_flags & ~flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_valid     <= 1'b0;
         s2_set_flags <= 1'b0;
         negative_o   <= 1'b0;
         zero_o       <= 1'b0;
         carry_o      <= 1'b0;
         overflow_o   <= 1'b0;
      end else begin
         s2_valid     <= s1_valid & ~flush_i;
         s2_set_flags <= s1_set_flags;
         if (write_en) begin
            negative_o <= s1_sign;
            zero_o     <= z_reduced;
            carry_o    <= s1_carry;
            overflow_o <= s1_overflow;
         end
      end
   end

   assign flags_valid_o = s2_valid & s2_set_flags;

endmodule
